// File: rtl/adc_pattern_monitor_pkg.sv
// Shared definitions for the ADC test-pattern monitor: pattern type codes,
// per-channel FSM states and PRBS polynomial constants.
package adc_pattern_monitor_pkg;

    localparam logic [3:0] TYP_ZERO   = 4'd0;
    localparam logic [3:0] TYP_ONES   = 4'd1;
    localparam logic [3:0] TYP_ALT    = 4'd4;
    localparam logic [3:0] TYP_PRBS23 = 4'd5;
    localparam logic [3:0] TYP_PRBS9  = 4'd6;
    localparam logic [3:0] TYP_TOGGLE = 4'd7;
    localparam logic [3:0] TYP_USER   = 4'd8;
    localparam logic [3:0] TYP_FIX    = 4'd9;
    localparam logic [3:0] TYP_SYNC   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_CHECK = 2'd2
    } mon_state_e;

    // x^23+x^18+1 and x^9+x^5+1: new bit = bit[n-K] ^ bit[n-TAP]
    localparam int PRBS23_K   = 23;
    localparam int PRBS23_TAP = 18;
    localparam int PRBS9_K    = 9;
    localparam int PRBS9_TAP  = 5;

    function automatic int h_words(input int k, input int dw);
        return (k + dw - 1) / dw;
    endfunction

    function automatic logic type_checked(input logic [3:0] t);
        case (t)
            TYP_ZERO, TYP_ONES, TYP_ALT, TYP_PRBS23, TYP_PRBS9,
            TYP_TOGGLE, TYP_USER, TYP_FIX, TYP_SYNC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/adc_pattern_monitor_prbs_next.sv
// Predicts the next DW PRBS bits from the last K received bits (bit 0 newest).
// The first predicted bit lands in word bit DW-1.
module prbs_next #(
    parameter int DW  = 12,
    parameter int K   = 23,
    parameter int TAP = 18
) (
    input  logic [K-1:0]  hist_i,
    output logic [DW-1:0] exp_o
);

    logic [K-1:0] st;
    logic         nb;

    always_comb begin
        st    = hist_i;
        nb    = 1'b0;
        exp_o = '0;
        for (int i = 0; i < DW; i++) begin
            nb             = st[K-1] ^ st[TAP-1];
            exp_o[DW-1-i]  = nb;
            st             = {st[K-2:0], nb};
        end
    end

endmodule

// File: rtl/adc_pattern_monitor.sv
// Per-channel ADC test-pattern checker: 3-stage pipeline (sample, predict/compare,
// FSM + counters) with lock tracking, saturating error counters and sticky bit maps.
module adc_pattern_monitor
    import adc_pattern_monitor_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int DW     = 12,
    parameter int CW     = 16,
    parameter int LOSS_N = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NCH*DW-1:0] data_i,
    input  logic [3:0]        type_i,
    input  logic [DW-1:0]     pattern_i,
    input  logic              count_i,
    input  logic              clr_i,
    output logic [NCH*CW-1:0] cnt_o,
    output logic [NCH*DW-1:0] err_bits_o,
    output logic [NCH-1:0]    lock_o,
    output logic [NCH-1:0]    loss_o
);

    localparam int HK  = PRBS23_K;
    localparam int H23 = h_words(PRBS23_K, DW);
    localparam int H9  = h_words(PRBS9_K, DW);
    localparam int LW  = $clog2(LOSS_N + 1);

    function automatic logic [DW-1:0] alt_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW; i++) w[i] = (((DW - 1 - i) % 2) == 0);
        return w;
    endfunction

    localparam logic [DW-1:0] ALT_W  = alt_word();
    localparam logic [DW-1:0] SYNC_W = {DW{1'b1}} >> (DW - DW / 2);

    logic       v1_q, v2_q, pv_q;
    logic [3:0] typ1_q, typ2_q, ptyp_q;
    logic       cen1_q, cen2_q;
    logic       type_chg, chk2;
    logic [1:0] hneed2;

    // Type and count travel with the word so a type switch takes effect
    // exactly on the first word sampled under the new type.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            pv_q   <= 1'b0;
            typ1_q <= '0;
            typ2_q <= '0;
            ptyp_q <= '0;
            cen1_q <= 1'b0;
            cen2_q <= 1'b0;
        end else begin
            v1_q   <= 1'b1;
            typ1_q <= type_i;
            cen1_q <= count_i;
            v2_q   <= v1_q;
            typ2_q <= typ1_q;
            cen2_q <= cen1_q;
            if (v2_q) begin
                pv_q   <= 1'b1;
                ptyp_q <= typ2_q;
            end
        end
    end

    assign type_chg = v2_q && pv_q && (typ2_q != ptyp_q);
    assign chk2     = type_checked(typ2_q);

    always_comb begin
        hneed2 = 2'd1;
        if (typ2_q == TYP_PRBS23)     hneed2 = 2'(H23);
        else if (typ2_q == TYP_PRBS9) hneed2 = 2'(H9);
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW-1:0] data_q, xor_q, exp1, e23, e9, prev;
        logic [DW-1:0] err_q, err_d;
        logic [HK-1:0] hist_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [LW-1:0] run_q, run_d;
        logic [1:0]    seed_q, seed_d;
        logic          loss_q, loss_d;
        mon_state_e    st_q, st_d;

        prbs_next #(.DW(DW), .K(PRBS23_K), .TAP(PRBS23_TAP)) u_prbs23 (
            .hist_i (hist_q[PRBS23_K-1:0]),
            .exp_o  (e23)
        );

        prbs_next #(.DW(DW), .K(PRBS9_K), .TAP(PRBS9_TAP)) u_prbs9 (
            .hist_i (hist_q[PRBS9_K-1:0]),
            .exp_o  (e9)
        );

        assign prev = hist_q[DW-1:0];

        always_comb begin
            exp1 = '0;
            case (typ1_q)
                TYP_ZERO:   exp1 = '0;
                TYP_ONES:   exp1 = '1;
                TYP_ALT:    exp1 = (prev == ALT_W) ? ~ALT_W : ALT_W;
                TYP_PRBS23: exp1 = e23;
                TYP_PRBS9:  exp1 = e9;
                TYP_TOGGLE: exp1 = (prev == '1) ? '0 : '1;
                TYP_USER:   exp1 = pattern_i;
                TYP_FIX:    exp1 = ALT_W;
                TYP_SYNC:   exp1 = SYNC_W;
                default:    exp1 = '0;
            endcase
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                data_q <= '0;
                xor_q  <= '0;
                hist_q <= '0;
            end else begin
                data_q <= data_i[c*DW +: DW];
                if (v1_q) begin
                    xor_q  <= data_q ^ exp1;
                    hist_q <= {hist_q[HK-DW-1:0], data_q};
                end
            end
        end

        always_comb begin
            st_d   = st_q;
            seed_d = seed_q;
            run_d  = run_q;
            cnt_d  = cnt_q;
            err_d  = err_q;
            loss_d = loss_q;
            if (v2_q) begin
                if (type_chg || !chk2) begin
                    st_d   = chk2 ? ST_SEED : ST_IDLE;
                    seed_d = '0;
                    run_d  = '0;
                end else begin
                    case (st_q)
                        ST_IDLE: begin
                            st_d   = ST_SEED;
                            seed_d = '0;
                        end
                        ST_SEED: begin
                            if (seed_q + 2'd1 >= hneed2) begin
                                st_d   = ST_CHECK;
                                seed_d = '0;
                                run_d  = '0;
                            end else begin
                                seed_d = seed_q + 2'd1;
                            end
                        end
                        ST_CHECK: begin
                            if (|xor_q) begin
                                err_d = err_q | xor_q;
                                if (cen2_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
                                if (run_q == LW'(LOSS_N - 1)) begin
                                    st_d   = ST_SEED;
                                    loss_d = 1'b1;
                                    run_d  = '0;
                                end else begin
                                    run_d = run_q + 1'b1;
                                end
                            end else begin
                                run_d = '0;
                            end
                        end
                        default: st_d = ST_SEED;
                    endcase
                end
            end
            if (clr_i) begin
                cnt_d  = '0;
                err_d  = '0;
                loss_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                st_q   <= ST_SEED;
                seed_q <= '0;
                run_q  <= '0;
                cnt_q  <= '0;
                err_q  <= '0;
                loss_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                seed_q <= seed_d;
                run_q  <= run_d;
                cnt_q  <= cnt_d;
                err_q  <= err_d;
                loss_q <= loss_d;
            end
        end

        assign cnt_o[c*CW +: CW]      = cnt_q;
        assign err_bits_o[c*DW +: DW] = err_q;
        assign lock_o[c]              = (st_q == ST_CHECK);
        assign loss_o[c]              = loss_q;
    end

endmodule

// File: tb/tb_adc_pattern_monitor.sv
// Directed bench for adc_pattern_monitor: PRBS lock, injected errors, clr priority,
// reset, type switching and counter saturation with hand-derived expectations.
module tb_adc_pattern_monitor;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [47:0] data_i;
    logic [3:0]  type_i;
    logic [11:0] pattern_i;
    logic        count_i;
    logic        clr_i;
    logic [15:0] cnt_o;
    logic [47:0] err_bits_o;
    logic [3:0]  lock_o;
    logic [3:0]  loss_o;

    int errors = 0;
    int checks = 0;

    logic [22:0] g23;
    logic [8:0]  g9;
    logic [11:0] w;
    logic        tgl;

    adc_pattern_monitor #(.NCH(4), .DW(12), .CW(4), .LOSS_N(4)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .data_i     (data_i),
        .type_i     (type_i),
        .pattern_i  (pattern_i),
        .count_i    (count_i),
        .clr_i      (clr_i),
        .cnt_o      (cnt_o),
        .err_bits_o (err_bits_o),
        .lock_o     (lock_o),
        .loss_o     (loss_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [47:0] rep(input logic [11:0] x);
        return {x, x, x, x};
    endfunction

    // Serial PRBS sources: b[n] = b[n-23]^b[n-18] / b[n-9]^b[n-5], first bit into MSB
    task automatic next23(output logic [11:0] o);
        logic nb;
        for (int i = 0; i < 12; i++) begin
            nb        = g23[22] ^ g23[17];
            o[11 - i] = nb;
            g23       = {g23[21:0], nb};
        end
    endtask

    task automatic next9(output logic [11:0] o);
        logic nb;
        for (int i = 0; i < 12; i++) begin
            nb        = g9[8] ^ g9[4];
            o[11 - i] = nb;
            g9        = {g9[7:0], nb};
        end
    endtask

    initial begin
        reset_i   = 1'b1;
        data_i    = '0;
        type_i    = 4'd5;
        pattern_i = '0;
        count_i   = 1'b1;
        clr_i     = 1'b0;
        g23       = 23'h2ABCD1;
        g9        = 9'h1A5;
        tgl       = 1'b1;
        tick();
        tick();
        chk("reset_cnt",  cnt_o, 0);
        chk("reset_err",  err_bits_o, 0);
        chk("reset_lock", lock_o, 0);
        chk("reset_loss", loss_o, 0);

        // PRBS23: two seed words, lock after the second word clears stage 3
        reset_i = 1'b0;
        next23(w); data_i = rep(w);
        for (int i = 0; i < 3; i++) begin tick(); next23(w); data_i = rep(w); end
        chk("p23_lock_seeding", lock_o, 4'h0);
        tick(); next23(w); data_i = rep(w);
        chk("p23_lock", lock_o, 4'hF);
        for (int i = 0; i < 10000; i++) begin tick(); next23(w); data_i = rep(w); end
        chk("p23_cnt_clean",  cnt_o, 0);
        chk("p23_err_clean",  err_bits_o, 0);
        chk("p23_lock_held",  lock_o, 4'hF);
        chk("p23_loss_clean", loss_o, 0);

        // Switch to PRBS9, then reset pulse during CHECK
        type_i = 4'd6;
        next9(w); data_i = rep(w);
        tick(); next9(w); data_i = rep(w);
        tick(); next9(w); data_i = rep(w);
        tick(); next9(w); data_i = rep(w);
        chk("p9_switch_seed", lock_o, 4'h0);
        tick(); next9(w); data_i = rep(w);
        chk("p9_lock", lock_o, 4'hF);
        for (int i = 0; i < 5; i++) begin tick(); next9(w); data_i = rep(w); end
        chk("p9_cnt_clean", cnt_o, 0);
        chk("p9_lock_before_rst", lock_o, 4'hF);
        #3 reset_i = 1'b1;
        #1;
        chk("rst_async_lock", lock_o, 0);
        chk("rst_async_cnt",  cnt_o, 0);
        chk("rst_async_err",  err_bits_o, 0);
        chk("rst_async_loss", loss_o, 0);
        tick(); next9(w); data_i = rep(w);
        reset_i = 1'b0;
        tick(); next9(w); data_i = rep(w);
        tick(); next9(w); data_i = rep(w);
        chk("p9_relock_early", lock_o, 4'h0);
        tick(); next9(w); data_i = rep(w);
        chk("p9_relock", lock_o, 4'hF);

        // Fixed 1010.. with one bad word on channel 2
        type_i = 4'd9;
        data_i = rep(12'hAAA);
        for (int i = 0; i < 4; i++) tick();
        chk("fix_lock", lock_o, 4'hF);
        data_i = {12'hAAA, 12'hAAB, 12'hAAA, 12'hAAA};
        tick();
        data_i = rep(12'hAAA);
        tick();
        chk("fix_latency", cnt_o, 0);
        tick();
        chk("fix_cnt", cnt_o, 16'h0100);
        chk("fix_err", err_bits_o, 48'h000001000000);
        chk("fix_lock_kept", lock_o, 4'hF);

        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("clr_cnt", cnt_o, 0);
        chk("clr_err", err_bits_o, 0);

        // Toggle stream; mismatch on channel 1 coincides with clr
        type_i = 4'd7;
        for (int i = 0; i < 6; i++) begin
            data_i = rep(tgl ? 12'hFFF : 12'h000);
            tick();
            tgl = ~tgl;
        end
        chk("tog_lock", lock_o, 4'hF);
        chk("tog_cnt",  cnt_o, 0);
        if (!tgl) begin
            data_i = rep(12'h000);
            tick();
            tgl = 1'b1;
        end
        data_i = {12'hFFF, 12'hFFF, 12'hFFE, 12'hFFF};
        tick();
        data_i = rep(12'h000);
        tick();
        data_i = rep(12'hFFF);
        clr_i  = 1'b1;
        tick();
        clr_i  = 1'b0;
        data_i = rep(12'h000);
        chk("tog_clr_cnt", cnt_o, 0);
        chk("tog_clr_err", err_bits_o, 0);
        tick();
        chk("tog_resume_cnt", cnt_o, 16'h0010);
        chk("tog_resume_err", err_bits_o, 48'h000000FFF000);
        chk("tog_loss", loss_o, 0);

        // Alternating, then switch to user pattern
        type_i = 4'd4;
        tgl    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_i = rep(tgl ? 12'hAAA : 12'h555);
            tick();
            tgl = ~tgl;
        end
        chk("alt_lock", lock_o, 4'hF);
        chk("alt_cnt",  cnt_o, 16'h0010);
        type_i    = 4'd8;
        pattern_i = 12'h123;
        data_i    = rep(12'h123);
        tick();
        tick();
        chk("usr_old_lock", lock_o, 4'hF);
        tick();
        chk("usr_seed", lock_o, 4'h0);
        tick();
        chk("usr_lock", lock_o, 4'hF);
        for (int i = 0; i < 4; i++) tick();
        chk("usr_cnt", cnt_o, 16'h0010);

        // All-ones expected, zeros received: loss after 4 words, saturation at 0xF
        type_i = 4'd1;
        data_i = '0;
        clr_i  = 1'b1;
        tick();
        clr_i  = 1'b0;
        chk("ones_clr", cnt_o, 0);
        tick();
        tick();
        chk("ones_seed", lock_o, 4'h0);
        tick();
        chk("ones_lock", lock_o, 4'hF);
        for (int i = 0; i < 3; i++) tick();
        chk("ones_cnt3",  cnt_o, 16'h3333);
        chk("ones_lock3", lock_o, 4'hF);
        chk("ones_loss3", loss_o, 4'h0);
        tick();
        chk("ones_cnt4",  cnt_o, 16'h4444);
        chk("ones_drop",  lock_o, 4'h0);
        chk("ones_loss",  loss_o, 4'hF);
        chk("ones_err",   err_bits_o, {4{12'hFFF}});
        for (int i = 0; i < 30; i++) tick();
        chk("ones_sat", cnt_o, 16'hFFFF);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("ones_clr_cnt",  cnt_o, 0);
        chk("ones_clr_loss", loss_o, 0);

        type_i = 4'd2;
        for (int i = 0; i < 4; i++) tick();
        chk("idle_lock", lock_o, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_pattern_monitor.md
ADC_PATTERN_MONITOR -- requirements
Module: adc_pattern_monitor

Interface
REQ-001 Parameter NCH, default 4, number of independent ADC channels checked.
REQ-002 Parameter DW, default 12, ADC word width in bits; legal range 8..16.
REQ-003 Parameter CW, default 16, per-channel error counter width.
REQ-004 Parameter LOSS_N, default 4, consecutive mismatching words that drop lock.
REQ-005 clk  input  1  ADC data clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset of all state.
REQ-007 data  input  NCH*DW  ADC words, channel i at bits [i*DW +: DW].
REQ-008 type  input  4  pattern type, common to all channels.
REQ-009 pattern  input  DW  user fixed word for type 8.
REQ-010 count  input  1  error counting enable.
REQ-011 clr  input  1  synchronous clear of counters, sticky maps and loss events.
REQ-012 cnt  output  NCH*CW  saturating per-channel error counters.
REQ-013 err_bits  output  NCH*DW  sticky per-bit mismatch map since last clr/reset.
REQ-014 lock  output  NCH  channel is in CHECK state.
REQ-015 loss  output  NCH  sticky flag: channel dropped lock at least once.

Function
REQ-016 Expected word per type: 0 all zeros; 1 all ones; 4 alternating 1010.. / 0101.. (next = complement of 1010.. pattern if previous received word equals 1010.., else 1010..); 5 PRBS23 (x^23+x^18+1); 6 PRBS9 (x^9+x^5+1); 7 toggle (next = 0 if previous received word all ones, else all ones); 8 pattern input; 9 fixed 1010.. (MSB=1); 10 sync word, low floor(DW/2) bits ones, rest zeros; other types: no checking.
REQ-017 PRBS serial order: word bit DW-1 is earliest; expected word = next DW LFSR outputs after the last K received bits (K=23 or 9), history taken from the last H=ceil(K/DW) received words.
REQ-018 Per-channel FSM states IDLE, SEED, CHECK; IDLE when type unchecked, otherwise SEED after reset.
REQ-019 SEED collects H received words (H=1 for non-PRBS types), then enters CHECK; no errors counted in SEED.
REQ-020 In CHECK each word is compared with its expected word; mismatch increments cnt when count=1, ORs XOR into err_bits regardless of count.
REQ-021 LOSS_N consecutive mismatches in CHECK -> SEED, set loss; any match resets the consecutive counter.
REQ-022 Any change of type -> all channels to SEED (or IDLE), consecutive counters cleared; cnt/err_bits untouched.
REQ-023 Latency: a word sampled at edge n is reflected in cnt/err_bits/lock after edge n+2.
REQ-024 cnt saturates at all ones and never wraps.
REQ-025 clr has priority over a simultaneous increment: cnt=0, err_bits=0, loss=0 after the edge; FSM state unaffected.
REQ-026 Channels are fully independent; an error on channel i never affects channel j.

Reset
REQ-027 reset asserted: cnt=0, err_bits=0, loss=0, lock=0, FSM=SEED/IDLE per type, pipeline registers=0, immediately and asynchronously.
REQ-028 reset mid-SEED or mid-CHECK discards partial history; seeding restarts after release.

Structure
REQ-029 Shared package holds type codes, FSM state enum, PRBS polynomial/order constants.
REQ-030 One sub-module prbs_next (combinational, parameters DW and polynomial): history in, expected word out; instantiated once per channel per PRBS type.
REQ-031 Per-channel logic in a generate loop; no logic shared between channels except type decode.

Verification
REQ-032 type=5, DW=12, clean PRBS23 stream on all channels -> lock=1 after 3 words, cnt=0 for 10000 words.
REQ-033 type=9, one word 0xAAB injected on channel 2 with count=1 -> cnt[2]=1, err_bits[2]=0x001, other channels 0.
REQ-034 type=1, data all zeros, count=1, CW=4 -> cnt saturates at 0xF, lock drops after 4 words, loss=1.
REQ-035 type=7 stream, clr and mismatch on the same edge -> cnt=0 after edge, counts resume next mismatch.
REQ-036 reset pulse during CHECK on type=6 -> all outputs 0 immediately; lock=1 again 3 cycles after release with clean PRBS9.
REQ-037 type switched 4->8 with pattern=0x123 and matching data -> one SEED word, then lock=1, cnt unchanged.
